cache_read_controller: RTL and testbench
========================================

Name: cache_read_controller

Overview:
- Sequencing controller for the 2-way, 8-set, 32-byte-line read cache. It owns the tag/valid/LRU state and the line storage, and performs the per-set tag compare, way select and byte select.
- Serves byte reads from the CPU side and refills missing lines from memory over a req/ack handshake.
- Sits between the CPU load port and the memory line interface.
- Keeps hit and miss statistics counters.

Parameters:
- ADDR_W, 16, byte address width. Address fields: tag = [ADDR_W-1:8], index = [7:5], offset = [4:0]. Legal range 9..32.
- COUNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  read request; accepted only when cpu_ready=1.
- cpu_addr  in  ADDR_W  byte address; sampled on accept.
- cpu_ready  out  1  high only in IDLE; request acceptance strobe = cpu_req & cpu_ready & ~flush.
- cpu_rvalid  out  1  one-cycle pulse; read data is valid.
- cpu_rdata  out  8  addressed byte; held until the next cpu_rvalid.
- cpu_hit  out  1  valid with cpu_rvalid: 1 = hit, 0 = served by refill.
- flush  in  1  invalidate all lines; acted on only in IDLE.
- mem_req  out  1  line fetch request.
- mem_addr  out  ADDR_W  line-aligned fetch address {tag, index, 5'b0}.
- mem_ack  in  1  fetch complete; mem_data valid this cycle; ignored while mem_req=0.
- mem_data  in  256  fetched line; byte k is bits [8k+7:8k].
- hit_count  out  COUNT_W  saturating hit counter.
- miss_count  out  COUNT_W  saturating miss counter.

Behaviour:
- Reset (synchronous, overrides everything):
  - state returns to IDLE.
  - all 16 valid bits and all 8 LRU bits are cleared.
  - cpu_rvalid, cpu_rdata, cpu_hit, mem_req, mem_addr, hit_count and miss_count all go to 0.
  - tag and data arrays are not reset.
  - reset in any state, including mid-miss, drops mem_req the next cycle; a late mem_ack after that is ignored.
- State machine: IDLE -> LOOKUP -> (hit) RESPOND -> IDLE; LOOKUP -> (miss) MISS -> (mem_ack) RESPOND -> IDLE.
- IDLE:
  - flush=1: clear all valid and LRU bits; any cpu_req that cycle is not accepted (flush wins).
  - otherwise, on cpu_req: latch cpu_addr and go to LOOKUP.
- LOOKUP (1 cycle):
  - way w hits when valid[w][index] is set and tag[w][index] equals the address tag. Way 0 has priority if both match; this cannot arise by construction.
  - on hit: latch the byte at the offset from the hit way's line, set cpu_hit=1, set lru[index] = ~w, increment hit_count, go to RESPOND.
  - on miss: assert mem_req and drive mem_addr, increment miss_count, go to MISS.
- MISS:
  - mem_req and mem_addr are held stable until mem_ack.
  - mem_ack may arrive in the first MISS cycle or any later cycle.
  - victim selection: way 0 if invalid; else way 1 if invalid; else way lru[index].
  - on mem_ack: write mem_data into the victim line, write its tag, set its valid bit, set lru[index] = ~victim, latch the byte at the offset from mem_data, set cpu_hit=0, deassert mem_req, go to RESPOND.
- RESPOND: cpu_rvalid=1 for exactly one cycle, then IDLE.
- Latency, with the request accepted at edge 0:
  - hit: cpu_rvalid high in cycle 2; cpu_ready high again in cycle 3.
  - miss with mem_ack in MISS cycle k (k>=0 counted from MISS entry): cpu_rvalid in cycle 3+k.
- cpu_req, flush and cpu_addr are don't-care outside IDLE; there is no queueing.
- Counters increment once per request and stay at all-ones when saturated.

Test Plan:
- Reset, read 0x1234 (tag 0x12, index 1, offset 20) -> mem_req=1 with mem_addr=0x1220. Reply with mem_ack and mem_data byte k = 0x40+k -> cpu_rvalid with cpu_rdata=0x54, cpu_hit=0, miss_count=1.
- Read 0x1234 again -> no mem_req; cpu_rvalid exactly 2 cycles after accept with cpu_rdata=0x54, cpu_hit=1, hit_count=1. Then read 0x1220 -> 0x40, hit.
- LRU on index 1:
  - fill 0x1220, then 0x5620 (way 1), then read 0x1220 (hit; LRU now points to way 1).
  - read 0x9A20 -> miss, evicts way 1.
  - read 0x1220 -> hit; read 0x5620 -> miss.
- Delay mem_ack by 5 cycles -> mem_req and mem_addr stable throughout, cpu_ready=0, toggling cpu_req ignored; cpu_rvalid 8 cycles after accept.
- Fill 0x1234, then flush and cpu_req in the same IDLE cycle -> request not accepted. Next read of 0x1234 -> miss.
- Assert reset while mem_req=1 -> mem_req=0 next cycle, cpu_ready=1, mem_ack 2 cycles later ignored. Previously filled 0x1234 now misses.
- With COUNT_W=4, 20 hits -> hit_count stays at 15.

Source files
------------

// File: rtl/cache_read_controller.sv
// Read controller for a 2-way, 8-set, 32-byte-line cache: tag compare, way/byte
// select, LRU victim choice, line refill over mem_req/mem_ack, hit/miss statistics.
module cache_read_controller #(
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_ready,
    output logic               cpu_rvalid,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_hit,
    input  logic               flush,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [255:0]       mem_data,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);

    localparam int TAG_W = ADDR_W - 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        MISS    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [TAG_W-1:0]    tag_mem_r  [2][8];
    logic [255:0]        data_mem_r [2][8];
    logic [1:0][7:0]     valid_r;
    logic [7:0]          lru_r;

    logic [TAG_W-1:0]    tag_s;
    logic [2:0]          index_s;
    logic [4:0]          offset_s;
    logic                hit0_s;
    logic                hit1_s;
    logic                hit_s;
    logic                hit_way_s;
    logic                victim_s;
    logic [255:0]        hit_line_s;
    logic [7:0]          hit_byte_s;
    logic [7:0]          fill_byte_s;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        if (value == {COUNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign tag_s    = addr_r[ADDR_W-1:8];
    assign index_s  = addr_r[7:5];
    assign offset_s = addr_r[4:0];

    // Tag compare, hit-way and victim selection, byte extraction from both line sources.
    always_comb begin
        hit0_s = valid_r[0][index_s] && (tag_mem_r[0][index_s] == tag_s);
        hit1_s = valid_r[1][index_s] && (tag_mem_r[1][index_s] == tag_s);
        hit_s  = hit0_s | hit1_s;
        if (hit0_s) begin
            hit_way_s = 1'b0;
        end else begin
            hit_way_s = 1'b1;
        end
        // Fill empty ways first so LRU only matters once the set is full.
        if (!valid_r[0][index_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][index_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[index_s];
        end
        hit_line_s  = data_mem_r[hit_way_s][index_s];
        hit_byte_s  = hit_line_s[{offset_s, 3'b000} +: 8];
        fill_byte_s = mem_data[{offset_s, 3'b000} +: 8];
    end

    // Sequencer with registered CPU/memory outputs, valid/LRU state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            valid_r    <= 16'h0000;
            lru_r      <= 8'h00;
            cpu_ready  <= 1'b1;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 8'h00;
            cpu_hit    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            hit_count  <= {COUNT_W{1'b0}};
            miss_count <= {COUNT_W{1'b0}};
        end else begin
            cpu_rvalid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        valid_r <= 16'h0000;
                        lru_r   <= 8'h00;
                    end else if (cpu_req) begin
                        addr_r    <= cpu_addr;
                        cpu_ready <= 1'b0;
                        state_r   <= LOOKUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        cpu_rdata         <= hit_byte_s;
                        cpu_hit           <= 1'b1;
                        cpu_rvalid        <= 1'b1;
                        lru_r[index_s]    <= ~hit_way_s;
                        hit_count         <= sat_inc(hit_count);
                        state_r           <= RESPOND;
                    end else begin
                        mem_req    <= 1'b1;
                        mem_addr   <= {tag_s, index_s, 5'b00000};
                        miss_count <= sat_inc(miss_count);
                        state_r    <= MISS;
                    end
                end
                MISS: begin
                    if (mem_ack) begin
                        valid_r[victim_s][index_s] <= 1'b1;
                        lru_r[index_s]             <= ~victim_s;
                        cpu_rdata                  <= fill_byte_s;
                        cpu_hit                    <= 1'b0;
                        cpu_rvalid                 <= 1'b1;
                        mem_req                    <= 1'b0;
                        state_r                    <= RESPOND;
                    end else begin
                        state_r <= MISS;
                    end
                end
                RESPOND: begin
                    cpu_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    mem_req   <= 1'b0;
                    cpu_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Line and tag storage carry no reset; the valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == MISS) && mem_ack) begin
            tag_mem_r[victim_s][index_s]  <= tag_s;
            data_mem_r[victim_s][index_s] <= mem_data;
        end
    end

endmodule

// File: tb/tb_cache_read_controller.sv
// Directed bench for cache_read_controller: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every cpu_rvalid.
module tb_cache_read_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic [15:0]  cpu_addr;
    logic         flush;
    logic         mem_ack;
    logic [255:0] mem_data;

    logic         cpu_ready, cpu_rvalid, cpu_hit, mem_req;
    logic [7:0]   cpu_rdata;
    logic [15:0]  mem_addr, hit_count, miss_count;

    logic         cpu_ready4, cpu_rvalid4, cpu_hit4, mem_req4;
    logic [7:0]   cpu_rdata4;
    logic [15:0]  mem_addr4;
    logic [3:0]   hit_count4, miss_count4;

    typedef struct {
        logic [7:0] data;
        logic       hit;
        int         hc;
        int         mc;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   post_rv = 1'b0;

    cache_read_controller #(.ADDR_W(16), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_hit(cpu_hit), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    cache_read_controller #(.ADDR_W(16), .COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready4), .cpu_rvalid(cpu_rvalid4), .cpu_rdata(cpu_rdata4),
        .cpu_hit(cpu_hit4), .flush(flush), .mem_req(mem_req4), .mem_addr(mem_addr4),
        .mem_ack(mem_ack), .mem_data(mem_data), .hit_count(hit_count4),
        .miss_count(miss_count4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [7:0] pat);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) d[8*k +: 8] = pat + 8'(k);
        return d;
    endfunction

    // Monitor: every rvalid pops one expected response; the following cycle must be idle.
    always @(negedge clk) begin
        exp_t e;
        if (post_rv) begin
            chk("rvalid_one_cycle", cpu_rvalid, 0);
            chk("ready_after_respond", cpu_ready, 1);
            post_rv = 1'b0;
        end else if (cpu_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rdata", cpu_rdata, e.data);
                chk("hit_flag", cpu_hit, e.hit);
                chk("hit_count", hit_count, e.hc);
                chk("miss_count", miss_count, e.mc);
                chk("hit_count_sat4", hit_count4, (e.hc > 15) ? 15 : e.hc);
                chk("miss_count_sat4", miss_count4, (e.mc > 15) ? 15 : e.mc);
                chk("rvalid_latency", cyc, e.cyc);
            end
            post_rv = 1'b1;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [15:0] addr, input bit exp_hit, input int delay,
                           input logic [7:0] pat, input logic [7:0] exp_data,
                           input int exp_hc, input int exp_mc);
        exp_t e;
        int   n;
        logic [15:0] line_addr;
        line_addr = {addr[15:5], 5'b00000};
        wait_ready();
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        e.data = exp_data;
        e.hit  = exp_hit;
        e.hc   = exp_hc;
        e.mc   = exp_mc;
        e.cyc  = exp_hit ? cyc + 1 : cyc + 2 + delay;
        sb.push_back(e);
        @(negedge clk);
        chk("lookup_mem_req", mem_req, 0);
        chk("lookup_ready", cpu_ready, 0);
        if (!exp_hit) begin
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk);
                chk("miss_mem_req", mem_req, 1);
                chk("miss_mem_addr", mem_addr, line_addr);
                chk("miss_ready", cpu_ready, 0);
                if (k == delay) begin
                    mem_ack  = 1'b1;
                    mem_data = line_of(pat);
                    cpu_req  = 1'b0;
                end else begin
                    cpu_req  = (k % 2 == 0);
                    cpu_addr = 16'hFFFF;
                end
            end
            @(posedge clk);
            #1;
            mem_ack  = 1'b0;
            mem_data = 256'h0;
            cpu_req  = 1'b0;
        end
        @(negedge clk);
        chk("respond_mem_req", mem_req, 0);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rvalid_timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 16'h0000;
        flush    = 1'b0;
        mem_ack  = 1'b0;
        mem_data = 256'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", cpu_ready, 1);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_rvalid", cpu_rvalid, 0);
        chk("reset_rdata", cpu_rdata, 0);
        chk("reset_hit", cpu_hit, 0);
        chk("reset_hit_count", hit_count, 0);
        chk("reset_miss_count", miss_count, 0);

        // Cold miss, then hits in the same line.
        do_read(16'h1234, 1'b0, 0, 8'h40, 8'h54, 0, 1);
        do_read(16'h1234, 1'b1, 0, 8'h00, 8'h54, 1, 1);
        do_read(16'h1220, 1'b1, 0, 8'h00, 8'h40, 2, 1);
        // LRU on index 1.
        do_read(16'h5620, 1'b0, 0, 8'h80, 8'h80, 2, 2);
        do_read(16'h1220, 1'b1, 0, 8'h00, 8'h40, 3, 2);
        do_read(16'h9A20, 1'b0, 0, 8'hC0, 8'hC0, 3, 3);
        do_read(16'h1220, 1'b1, 0, 8'h00, 8'h40, 4, 3);
        // Evicted line misses again; ack delayed by 5 cycles.
        do_read(16'h5625, 1'b0, 5, 8'h80, 8'h85, 4, 4);
        do_read(16'h0047, 1'b0, 2, 8'h10, 8'h17, 4, 5);
        do_read(16'h1234, 1'b1, 0, 8'h00, 8'h54, 5, 5);

        // Flush and request together: flush wins, request dropped.
        wait_ready();
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 16'h1234;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("flush_req_not_accepted", cpu_ready, 1);
        chk("flush_mem_req", mem_req, 0);
        do_read(16'h1234, 1'b0, 0, 8'h40, 8'h54, 5, 6);

        // Reset during a pending miss.
        wait_ready();
        cpu_req  = 1'b1;
        cpu_addr = 16'h7720;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_mem_req", mem_req, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midmiss_reset_mem_req", mem_req, 0);
        chk("midmiss_reset_ready", cpu_ready, 1);
        chk("midmiss_reset_miss_count", miss_count, 0);
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = line_of(8'h33);
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        mem_data = 256'h0;
        @(negedge clk);
        chk("late_ack_mem_req", mem_req, 0);
        chk("late_ack_ready", cpu_ready, 1);
        do_read(16'h1234, 1'b0, 1, 8'h40, 8'h54, 0, 1);

        // 20 hits: the 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            do_read(16'h1220 + 16'(i), 1'b1, 0, 8'h00, 8'h40 + 8'(i), i + 1, 1);
        end
        @(negedge clk);
        chk("final_hit_count", hit_count, 20);
        chk("final_hit_count4", hit_count4, 15);
        chk("final_miss_count4", miss_count4, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
